// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run-time programmable integer clock divider (sclk/s_rst in; en + cfg handshake in; div_clk/div_tick/busy/cur_div/period_cnt out; CLKDIV_PERIOD_CNT_EN enables period_cnt)
module clkdiv_ctrl #(
  parameter int CNT_W = 8,
  parameter int DEF_DIV = 5
) (
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             div_tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic [15:0]      period_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, pend_div, cnt_nx, div_nx;
  logic [CNT_W:0] half;
  logic xfer, legal, wrap;
  always_comb begin
    xfer = cfg_valid && cfg_ready;
    legal = cfg_div > CNT_W'(1);
    wrap = state != IDLE && cnt == cur_div - CNT_W'(1);
    cnt_nx = wrap ? '0 : cnt + CNT_W'(1);
    div_nx = wrap && !cfg_ready ? pend_div : cur_div;
    half = ({1'b0, div_nx} + (CNT_W+1)'(1)) >> 1;
  end
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state <= IDLE;
      cnt <= '0;
      cur_div <= CNT_W'(DEF_DIV);
      pend_div <= '0;
      cfg_ready <= 1'b1;
      cfg_err <= 1'b0;
      div_clk <= 1'b0;
      div_tick <= 1'b0;
      busy <= 1'b0;
    end else begin
      cfg_err <= xfer && !legal;
      if (state == IDLE) begin
        // a divisor queued on the final wrap is applied here instead of waiting for a wrap that never comes
        cur_div <= xfer && legal ? cfg_div : !cfg_ready ? pend_div : cur_div;
        cfg_ready <= 1'b1;
        if (en) begin
          state <= RUN;
          cnt <= '0;
          div_clk <= 1'b1;
          div_tick <= 1'b1;
          busy <= 1'b1;
        end
      end else begin
        cur_div <= div_nx;
        if (xfer && legal) pend_div <= cfg_div;
        cfg_ready <= !(xfer && legal) && (wrap || cfg_ready);
        if (state == STOP && !en && wrap) begin
          state <= IDLE;
          cnt <= '0;
          div_clk <= 1'b0;
          div_tick <= 1'b0;
          busy <= 1'b0;
        end else begin
          state <= en ? RUN : STOP;
          cnt <= cnt_nx;
          div_clk <= {1'b0, cnt_nx} < half;
          div_tick <= cnt_nx == '0;
        end
      end
    end
  end
`ifdef CLKDIV_PERIOD_CNT_EN
  always_ff @(posedge sclk) begin
    if (s_rst) period_cnt <= '0;
    else if (wrap && period_cnt != 16'hFFFF) period_cnt <= period_cnt + 16'd1;
  end
`else
  assign period_cnt = '0;
`endif
endmodule
